// File: rtl/fifo_word_reader.sv
// fifo_word_reader: pops bytes from a FIFO one at a time and packs them
// little-endian into 32-bit words. A word goes out when four bytes are
// collected, when flush is raised with a partial word, or when a partial
// word has sat with the FIFO empty for TIMEOUT idle cycles.
//
// Ports
//   read_clk    in   clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_out    in   [7:0] FIFO data, valid the cycle after read_en
//   read_en     out  FIFO pop strobe (registered, one cycle)
//   flush       in   emit the current partial word
//   word_out    out  [31:0] packed word, byte 0 in bits 7:0
//   word_bytes  out  [2:0] valid byte count 1..4
//   word_valid  out  word_out/word_bytes valid
//   word_ready  in   downstream accept

// One byte lane of the output word: captures on cap, zeroes on clr.
module fifo_word_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             clr,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (cap) q <= din;
  end
endmodule

module fifo_word_reader #(
  parameter int TIMEOUT = 16
) (
  input  logic        read_clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_out,
  output logic        read_en,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [2:0]  word_bytes,
  output logic        word_valid,
  input  logic        word_ready
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  logic [1:0] state;
  logic [2:0] lane_idx;
  logic [7:0] tmo_cnt;

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_q;
  logic [NUM_LANES-1:0]            lane_cap;
  logic                            accept;
  logic                            partial;

  assign accept  = (state == SEND) && word_ready;
  assign partial = (lane_idx != 3'd0);

  // Lane i captures the byte presented during CAPT when it is the next lane.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_cap[gi] = (state == CAPT) && (lane_idx == 3'(gi));
      fifo_word_lane #(.VEC_W(VEC_W)) u_lane (
        .clk (read_clk),
        .rst (reset),
        .cap (lane_cap[gi]),
        .clr (accept),
        .din (fifo_out),
        .q   (lane_q[gi])
      );
    end
  endgenerate

  assign word_out = lane_q;

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      read_en    <= 1'b0;
      word_valid <= 1'b0;
      word_bytes <= 3'd0;
      lane_idx   <= 3'd0;
      tmo_cnt    <= 8'd0;
    end else begin
      // Counts only while a partial word waits on an empty FIFO.
      if ((state == IDLE) && partial && fifo_empty) tmo_cnt <= tmo_cnt + 8'd1;
      else                                          tmo_cnt <= 8'd0;

      case (state)
        IDLE: begin
          // flush wins over a pending fetch; flush with no bytes is a no-op.
          if ((flush && partial) ||
              (partial && fifo_empty && (tmo_cnt == 8'(TIMEOUT - 1)))) begin
            state      <= SEND;
            word_valid <= 1'b1;
            word_bytes <= lane_idx;
          end else if (!fifo_empty) begin
            state   <= FETCH;
            read_en <= 1'b1;
          end
        end
        FETCH: begin
          state   <= CAPT;
          read_en <= 1'b0;
        end
        CAPT: begin
          lane_idx <= lane_idx + 3'd1;
          if (lane_idx == 3'(NUM_LANES - 1)) begin
            state      <= SEND;
            word_valid <= 1'b1;
            word_bytes <= 3'(NUM_LANES);
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (word_ready) begin
            state      <= IDLE;
            word_valid <= 1'b0;
            word_bytes <= 3'd0;
            lane_idx   <= 3'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
